// File: rtl/audio_pkg.sv
// Shared widths, limits and FSM encoding for the expansion-audio mixer.
package audio_pkg;

  localparam int unsigned SMP_W      = 16;
  localparam int unsigned GAIN_W     = 8;
  localparam int unsigned GAIN_SHIFT = 7;
  localparam int unsigned PROD_W     = SMP_W + GAIN_W;
  localparam logic [SMP_W-1:0] VOL_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    SAT  = 2'd2
  } state_e;

endpackage

// File: rtl/audio_mix_if.sv
// Channel inputs and mixed-sample outputs of the expansion-audio mixer.
interface audio_mix_if #(
  parameter int unsigned NCH = 4
);
  import audio_pkg::*;

  logic                         m2;
  logic [NCH-1:0][SMP_W-1:0]    ch_smp;
  logic [NCH-1:0][GAIN_W-1:0]   ch_gain;
  logic [NCH-1:0]               ch_en;
  logic                         mute;
  logic [SMP_W-1:0]             vol;
  logic                         vol_stb;
  logic                         ovr;

  modport master (
    output m2, ch_smp, ch_gain, ch_en, mute,
    input  vol, vol_stb, ovr
  );

  modport slave (
    input  m2, ch_smp, ch_gain, ch_en, mute,
    output vol, vol_stb, ovr
  );

endinterface

// File: rtl/m2_edge_det.sv
// Two-flop synchroniser for CPU M2 and a rising-edge tick in the clk domain.
module m2_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic m2_i,
  output logic rise_o_c
);

  logic [1:0] sync_q;
  logic       fill_q;
  logic       armed_q;

  // armed_q only sets once a genuine low has been sampled, so a high m2 at release is not a tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= 2'b00;
      fill_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], m2_i};
      fill_q  <= 1'b1;
      armed_q <= armed_q | (fill_q & ~sync_q[0]);
    end
  end

  assign rise_o_c = armed_q & sync_q[0] & ~sync_q[1];

endmodule

// File: rtl/audio_mix.sv
// Mixes NCH gained channel samples once per M2 tick through one shared 16x8 multiplier.
module audio_mix #(
  parameter int unsigned NCH = 4
) (
  input  logic        clk,
  input  logic        rst,
  audio_mix_if.slave  bus
);
  import audio_pkg::*;

  localparam int unsigned IDX_W = $clog2(NCH);
  localparam int unsigned ACC_W = PROD_W + $clog2(NCH);
  localparam int unsigned RES_W = ACC_W - GAIN_SHIFT;

  state_e                       state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [ACC_W-1:0]             acc_q;
  logic [ACC_W-1:0]             acc_d;
  logic [NCH-1:0][SMP_W-1:0]    smp_q;
  logic [NCH-1:0][GAIN_W-1:0]   gain_q;
  logic [NCH-1:0]               en_q;
  logic                         mute_q;
  logic [SMP_W-1:0]             vol_q;
  logic [SMP_W-1:0]             vol_d;
  logic                         vol_stb_q;
  logic                         ovr_q;
  logic                         rise_c;
  logic [PROD_W-1:0]            prod_c;
  logic [RES_W-1:0]             res_c;
  logic                         last_c;

  m2_edge_det u_edge (
    .clk      (clk),
    .rst      (rst),
    .m2_i     (bus.m2),
    .rise_o_c (rise_c)
  );

  // Single multiplier, operands selected by the channel index
  assign prod_c = PROD_W'(smp_q[idx_q]) * PROD_W'(gain_q[idx_q]);
  assign last_c = (idx_q == IDX_W'(NCH - 1));

  always_comb begin
    acc_d = acc_q;
    vol_d = vol_q;
    res_c = acc_q[ACC_W-1:GAIN_SHIFT];
    if (en_q[idx_q]) begin
      acc_d = acc_q + ACC_W'(prod_c);
    end
    if (mute_q) begin
      vol_d = '0;
    end else if (res_c > RES_W'(VOL_MAX)) begin
      vol_d = VOL_MAX;
    end else begin
      vol_d = res_c[SMP_W-1:0];
    end
  end

  // Ticks arriving while busy (MAC, or SAT as it returns to IDLE) are dropped and flagged
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      smp_q     <= '0;
      gain_q    <= '0;
      en_q      <= '0;
      mute_q    <= 1'b0;
      vol_q     <= '0;
      vol_stb_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      vol_stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise_c) begin
            smp_q   <= bus.ch_smp;
            gain_q  <= bus.ch_gain;
            en_q    <= bus.ch_en;
            mute_q  <= bus.mute;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (rise_c) ovr_q <= 1'b1;
          if (last_c) begin
            idx_q   <= '0;
            state_q <= SAT;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        SAT: begin
          vol_q     <= vol_d;
          vol_stb_q <= 1'b1;
          state_q   <= IDLE;
          if (rise_c) ovr_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vol     = vol_q;
  assign bus.vol_stb = vol_stb_q;
  assign bus.ovr     = ovr_q;

endmodule

// File: doc/audio_mix.md
AUDIO_MIX -- requirements
Module: audio_mix

Interface
REQ-001 Parameter NCH, default 4, number of expansion-audio channels mixed (2..8).
REQ-002 Signal clk  input  1  system clock, all logic on rising edge.
REQ-003 Signal rst  input  1  reset, synchronous, active-low.
REQ-004 Signal m2  input  1  CPU M2, asynchronous to clk; the rising edge is the sample tick.
REQ-005 Signal ch_smp  input  NCH x 16  unsigned channel samples from mapper sound sources.
REQ-006 Signal ch_gain  input  NCH x 8  unsigned per-channel gain; 128 = unity.
REQ-007 Signal ch_en  input  NCH  per-channel enable; 0 excludes the channel from the sum.
REQ-008 Signal mute  input  1  forces the next output sample to 0.
REQ-009 Signal vol  output  16  mixed sample, feeds the delta-sigma DAC vol input.
REQ-010 Signal vol_stb  output  1  one-clk pulse marking a new vol value.
REQ-011 Signal ovr  output  1  sticky overrun flag.

Function
REQ-012 m2 SHALL pass through a 2-flop synchroniser; an edge is detected in the cycle where the synchronised history equals 01 (old 0, new 1).
REQ-013 FSM states SHALL be IDLE, MAC and SAT; a single multiplier is time-shared across channels.
REQ-014 IDLE + edge: snapshot ch_smp, ch_gain, ch_en and mute, clear accumulator, clear index, go to MAC.
REQ-015 MAC: each clk, add ch_smp[idx]*ch_gain[idx] (16x8 product) to the accumulator if snapshot ch_en[idx]=1, else add 0; idx increments by 1.
REQ-016 MAC SHALL last exactly NCH clocks; after idx = NCH-1, go to SAT.
REQ-017 Accumulator width SHALL be 24 + clog2(NCH) bits so no intermediate overflow occurs.
REQ-018 SAT: result = accumulator >> 7; if result > 0xFFFF, vol = 0xFFFF (saturate, no wrap); if snapshot mute = 1, vol = 0.
REQ-019 SAT SHALL register vol and pulse vol_stb for exactly one clk, then return to IDLE.
REQ-020 Latency: vol and vol_stb SHALL become visible exactly NCH+2 clocks after the edge-detect cycle.
REQ-021 vol SHALL hold its value between strobes; input changes outside the snapshot cycle SHALL have no effect on the sample in progress.
REQ-022 An edge detected while the FSM is in MAC or SAT SHALL be dropped (no restart) and SHALL set ovr = 1.
REQ-023 An edge detected in the same cycle that SAT returns to IDLE SHALL count as busy: it is dropped and sets ovr.
REQ-024 ovr SHALL clear only on reset.
REQ-025 gain = 0 on every channel, or ch_en = 0, SHALL yield vol = 0 with a normal strobe.

Reset
REQ-026 rst = 0 at a clk edge SHALL force: state IDLE, vol = 0, vol_stb = 0, ovr = 0, accumulator = 0, idx = 0, synchroniser = 00.
REQ-027 Reset asserted mid-MAC or mid-SAT SHALL abort the sample with no vol_stb pulse.
REQ-028 After reset deasserts, the first tick SHALL be the first 0->1 transition seen by the synchroniser; a high m2 at release SHALL not produce a tick.

Structure
REQ-029 Package audio_pkg SHALL hold SMP_W = 16, GAIN_W = 8, GAIN_SHIFT = 7, VOL_MAX = 16'hFFFF and the FSM state enum.
REQ-030 Sub-module m2_edge_det SHALL contain the synchroniser and the rising-edge pulse; all other logic lives in audio_mix.
REQ-031 The multiplier SHALL be a single 16x8 unsigned instance, with no per-channel multipliers.

Verification
REQ-032 Reset: hold rst = 0 while toggling m2 and driving non-zero inputs -> vol = 0, vol_stb = 0, ovr = 0 throughout.
REQ-033 Unity: ch0 = 0x4000, gain0 = 128, ch_en = 0001, other channels = 0 -> vol = 0x4000, vol_stb exactly 6 clk after edge detect (NCH = 4).
REQ-034 Mix/mask: ch0 = 0x8000, gain0 = 64; ch1 = 0x1000, gain1 = 128; ch_en = 0001 -> vol = 0x4000. With ch_en = 0011 -> vol = 0x5000.
REQ-035 Saturation: all four channels = 0xFFFF, gain = 255, all enabled -> vol = 0xFFFF. Then mute = 1 on the next tick -> vol = 0x0000.
REQ-036 Overrun: two m2 rising edges 3 clk apart -> one vol_stb only, ovr = 1 and stays 1 until rst.
REQ-037 Mid-operation reset: rst = 0 for 1 clk during MAC idx = 2 -> no strobe, vol = 0; the next tick yields the correct sample.
